// File: rtl/tri_area_cmp.sv
// Largest of three right-triangle areas plus the longer leg of the winner.
// Optional `TRI_IDX_EN adds a registered win_idx output.
module tri_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module tri_ge #(
    parameter int W = 17
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         ge
);
    logic [W:0] c;

    // Ripple from LSB: equal prefix keeps the lower verdict.
    assign c[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            assign c[i+1] = (x[i] & ~y[i])
                          | (~(x[i] ^ y[i]) & c[i]);
        end
    endgenerate

    assign ge = c[W];
endmodule

module tri_half_mul (
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    output logic [16:0] half
);
    // Row-ripple array multiplier returning bits [17:1] of x*y.
    logic [8:0] pp [9];
    logic [8:0] top0;
    logic [9:0] s  [1:8];
    logic [8:0] cy [1:8];
    logic [6:0] lo;

    genvar i, j;
    generate
        for (i = 0; i < 9; i++) begin : g_pp
            assign pp[i] = x & {9{y[i]}};
        end

        assign top0 = {1'b0, x[8:1] & {8{y[0]}}};

        for (i = 1; i < 9; i++) begin : g_row
            logic [8:0] up;

            if (i == 1) begin : g_first
                assign up = top0;
            end else begin : g_next
                assign up = s[i-1][9:1];
            end

            for (j = 0; j < 9; j++) begin : g_col
                logic cin;

                if (j == 0) begin : g_c0
                    assign cin = 1'b0;
                end else begin : g_cn
                    assign cin = cy[i][j-1];
                end

                tri_fa u_fa (
                    .a  (up[j]),
                    .b  (pp[i][j]),
                    .ci (cin),
                    .s  (s[i][j]),
                    .co (cy[i][j])
                );
            end

            assign s[i][9] = cy[i][8];
        end

        for (i = 1; i < 8; i++) begin : g_lo
            assign lo[i-1] = s[i][0];
        end
    endgenerate

    assign half = {s[8], lo};
endmodule

module tri_area_cmp (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  a,
    input  logic [8:0]  b,
    input  logic [8:0]  c,
    input  logic [8:0]  d,
    input  logic [8:0]  e,
    input  logic [8:0]  f,
`ifdef TRI_IDX_EN
    output logic [1:0]  win_idx,
`endif
    output logic [16:0] out,
    output logic [8:0]  max
);
    logic [16:0] area0, area1, area2;
    logic        ge01, ge02, ge12;
    logic        lg0, lg1, lg2;
    logic        w0, w1, w2;
    logic [8:0]  leg0, leg1, leg2;
    logic [16:0] area_n;
    logic [8:0]  max_n;
    logic [1:0]  idx_n;

    tri_half_mul u_m0 (.x(a), .y(b), .half(area0));
    tri_half_mul u_m1 (.x(c), .y(d), .half(area1));
    tri_half_mul u_m2 (.x(e), .y(f), .half(area2));

    tri_ge #(.W(17)) u_g01 (.x(area0), .y(area1), .ge(ge01));
    tri_ge #(.W(17)) u_g02 (.x(area0), .y(area2), .ge(ge02));
    tri_ge #(.W(17)) u_g12 (.x(area1), .y(area2), .ge(ge12));

    tri_ge #(.W(9)) u_l0 (.x(a), .y(b), .ge(lg0));
    tri_ge #(.W(9)) u_l1 (.x(c), .y(d), .ge(lg1));
    tri_ge #(.W(9)) u_l2 (.x(e), .y(f), .ge(lg2));

    assign leg0 = lg0 ? a : b;
    assign leg1 = lg1 ? c : d;
    assign leg2 = lg2 ? e : f;

    // Using >= gives ties to the lower index.
    assign w0 = ge01 & ge02;
    assign w1 = ~w0 & ge12;
    assign w2 = ~w0 & ~ge12;

    always_comb begin
        area_n = '0;
        max_n  = '0;
        idx_n  = 2'd0;
        unique case (1'b1)
            w0: begin
                area_n = area0;
                max_n  = leg0;
                idx_n  = 2'd0;
            end
            w1: begin
                area_n = area1;
                max_n  = leg1;
                idx_n  = 2'd1;
            end
            w2: begin
                area_n = area2;
                max_n  = leg2;
                idx_n  = 2'd2;
            end
            default: begin
                area_n = '0;
                max_n  = '0;
                idx_n  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            max <= '0;
        end else begin
            out <= area_n;
            max <= max_n;
        end
    end

`ifdef TRI_IDX_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            win_idx <= 2'd0;
        end else begin
            win_idx <= idx_n;
        end
    end
`else
    logic idx_unused;
    assign idx_unused = ^idx_n;
`endif
endmodule

// File: tb/tb_tri_area_cmp.sv
// Randomised and directed bench for tri_area_cmp against a plain
// arithmetic reference model.
module tb_tri_area_cmp;
    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  a, b, c, d, e, f;
    logic [16:0] out;
    logic [8:0]  max;
`ifdef TRI_IDX_EN
    logic [1:0]  win_idx;
`endif

    int n_chk = 0;
    int n_err = 0;

    int          exp_out;
    int          exp_max;
    int          exp_idx;

    always #5 clk = ~clk;

    tri_area_cmp dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
`ifdef TRI_IDX_EN
        .win_idx (win_idx),
`endif
        .out     (out),
        .max     (max)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: integer areas, strict > scan keeps lowest index on ties.
    task automatic model(input int rst_v);
        int ar [3];
        int lg [3][2];
        int w;
        lg[0][0] = a; lg[0][1] = b;
        lg[1][0] = c; lg[1][1] = d;
        lg[2][0] = e; lg[2][1] = f;
        for (int k = 0; k < 3; k++)
            ar[k] = (lg[k][0] * lg[k][1]) / 2;
        w = 0;
        for (int k = 1; k < 3; k++)
            if (ar[k] > ar[w]) w = k;
        if (rst_v != 0) begin
            exp_out = 0;
            exp_max = 0;
            exp_idx = 0;
        end else begin
            exp_out = ar[w];
            exp_max = (lg[w][0] > lg[w][1]) ? lg[w][0] : lg[w][1];
            exp_idx = w;
        end
    endtask

    task automatic step(input string tag);
        model(int'(rst));
        @(posedge clk);
        #1;
        chk({tag, ".out"}, int'(out), exp_out);
        chk({tag, ".max"}, int'(max), exp_max);
`ifdef TRI_IDX_EN
        chk({tag, ".idx"}, int'(win_idx), exp_idx);
`endif
    endtask

    task automatic set6(input int va, vb, vc, vd, ve, vf);
        a = 9'(va); b = 9'(vb); c = 9'(vc);
        d = 9'(vd); e = 9'(ve); f = 9'(vf);
    endtask

    function automatic int rv();
        if ($urandom_range(0, 3) == 0)
            return int'($urandom_range(0, 4));
        return int'($urandom_range(0, 511));
    endfunction

    initial begin
        rst = 1'b1;
        set6(511, 511, 511, 511, 511, 511);
        step("rst0");
        step("rst1");
        rst = 1'b0;
        step("full");

        set6(3, 4, 5, 6, 1, 1);
        step("basic");
        set6(3, 5, 2, 7, 0, 9);
        step("trunc_tie01");
        set6(0, 0, 4, 4, 2, 8);
        step("tie12");
        set6(0, 0, 0, 0, 10, 20);
        step("win2");
        set6(0, 0, 0, 0, 0, 0);
        step("zero");
        set6(0, 7, 0, 3, 0, 9);
        step("zero_leg");

        for (int i = 0; i < 200; i++) begin
            set6(rv(), rv(), rv(), rv(), rv(), rv());
            rst = (i == 100) ? 1'b1 : 1'b0;
            step($sformatf("rnd%0d", i));
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
